// File: rtl/flappy_pkg.sv
// Shared types and screen geometry for the Flappy Bird game datapaths.
package flappy_pkg;

   typedef enum logic [1:0] {IDLE, PLAYING, DYING, GAME_OVER} game_state_t;

   localparam int SCREEN_H   = 480;
   localparam int BIRD_X     = 160;
   localparam int BIRD_SIZE  = 15;
   localparam int PIPE_W     = 40;

   // Bird horizontal extent, inclusive on both sides.
   localparam int BIRD_LEFT  = BIRD_X - BIRD_SIZE / 2;
   localparam int BIRD_RIGHT = BIRD_X + BIRD_SIZE / 2;

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the key, bird and pipe side.
interface game_ctrl_if #(
   parameter int N       = 10,
   parameter int SCORE_W = 8
);
   logic               key;
   logic [N-1:0]       bird_y0;
   logic [N-1:0]       bird_y1;
   logic [N-1:0]       pipe_x;
   logic [N-1:0]       gap_top;
   logic [N-1:0]       gap_bot;
   logic               bird_rst;
   logic               flap;
   logic               tick;
   logic               running;
   logic               game_over;
   logic [SCORE_W-1:0] score;

   modport master (
      output key, bird_y0, bird_y1, pipe_x, gap_top, gap_bot,
      input  bird_rst, flap, tick, running, game_over, score
   );

   modport slave (
      input  key, bird_y0, bird_y1, pipe_x, gap_top, gap_bot,
      output bird_rst, flap, tick, running, game_over, score
   );
endinterface

// File: rtl/game_ctrl_key_sync_edge.sv
// Two-flop synchronizer for the raw flap key plus a one-cycle rising-edge pulse.
module key_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_key,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_key_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_key_q <= 1'b0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         r_key_q <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 & ~r_key_q;

endmodule

// File: rtl/game_ctrl.sv
// Flappy Bird game sequencer: flap pulses, physics tick, collision and score,
// and the IDLE/PLAYING/DYING/GAME_OVER flow. All outputs are registered.
module game_ctrl
   import flappy_pkg::*;
#(
   parameter int N          = 10,
   parameter int SCORE_W    = 8,
   parameter int TICK_DIV   = 6250000,
   parameter int DEATH_HOLD = 8
) (
   input logic        clk,
   input logic        reset,
   game_ctrl_if.slave bus
);

   localparam int NP1 = N + 1;
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW  = $clog2(DEATH_HOLD + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_HOLD - 1);

   game_state_t        r_state, w_state_next;
   logic [TW-1:0]      r_tick_cnt, w_tick_cnt_next;
   logic [DW-1:0]      r_death_cnt, w_death_cnt_next;
   logic [SCORE_W-1:0] r_score, w_score_next;
   logic               r_passed, r_bird_rst, r_flap, r_tick, r_running, r_game_over;
   logic               w_flap_next, w_tick_next, w_tick_fire, w_tick_active;
   logic               w_key_pulse, w_hit, w_x_overlap, w_passed, w_pass_evt;
   logic [N:0]         w_pipe_right;

   key_sync_edge u_key (
      .clk     (clk),
      .reset   (reset),
      .i_key   (bus.key),
      .o_pulse (w_key_pulse)
   );

   // Right edge is one bit wider so a pipe near the right border cannot wrap.
   assign w_pipe_right = {1'b0, bus.pipe_x} + NP1'(PIPE_W);
   assign w_x_overlap  = (bus.pipe_x <= N'(BIRD_RIGHT)) && (w_pipe_right > NP1'(BIRD_LEFT));
   assign w_hit        = (bus.bird_y0 >= N'(SCREEN_H - 1)) || (bus.bird_y1 == '0) ||
                         (w_x_overlap && ((bus.bird_y1 < bus.gap_top) || (bus.bird_y0 > bus.gap_bot)));
   assign w_passed     = w_pipe_right < NP1'(BIRD_LEFT);
   assign w_pass_evt   = w_passed & ~r_passed;

   assign w_tick_active = (r_state == PLAYING) || (r_state == DYING);
   assign w_tick_fire   = w_tick_active && (r_tick_cnt == TICK_LAST);

   always_comb begin
      w_state_next     = r_state;
      w_score_next     = r_score;
      w_death_cnt_next = r_death_cnt;
      w_flap_next      = 1'b0;
      case (r_state)
         IDLE: begin
            w_death_cnt_next = '0;
            if (w_key_pulse) begin
               w_state_next = PLAYING;
               w_score_next = '0;
            end
         end
         PLAYING: begin
            if (w_hit) begin
               w_state_next = DYING;
            end else begin
               w_flap_next = w_key_pulse;
               if (w_pass_evt && (r_score != '1))
                  w_score_next = r_score + 1'b1;
            end
         end
         DYING: begin
            if (r_tick) begin
               if (r_death_cnt == DEATH_LAST) begin
                  w_state_next     = GAME_OVER;
                  w_death_cnt_next = '0;
               end else begin
                  w_death_cnt_next = r_death_cnt + 1'b1;
               end
            end
         end
         GAME_OVER: begin
            if (w_key_pulse)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase

      // Counter idles at zero outside PLAYING/DYING, so entry into PLAYING starts a full period.
      w_tick_cnt_next = '0;
      if (w_tick_active && !w_tick_fire)
         w_tick_cnt_next = r_tick_cnt + 1'b1;
      w_tick_next = w_tick_fire && ((w_state_next == PLAYING) || (w_state_next == DYING));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_tick_cnt  <= '0;
         r_death_cnt <= '0;
         r_score     <= '0;
         r_passed    <= 1'b0;
         r_bird_rst  <= 1'b1;
         r_flap      <= 1'b0;
         r_tick      <= 1'b0;
         r_running   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_tick_cnt  <= w_tick_cnt_next;
         r_death_cnt <= w_death_cnt_next;
         r_score     <= w_score_next;
         r_passed    <= w_passed;
         r_bird_rst  <= (w_state_next == IDLE);
         r_flap      <= w_flap_next;
         r_tick      <= w_tick_next;
         r_running   <= (w_state_next == PLAYING);
         r_game_over <= (w_state_next == GAME_OVER);
      end
   end

   assign bus.bird_rst  = r_bird_rst;
   assign bus.flap      = r_flap;
   assign bus.tick      = r_tick;
   assign bus.running   = r_running;
   assign bus.game_over = r_game_over;
   assign bus.score     = r_score;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for Flappy Bird.
- Turns the raw flap key into clean one-cycle flap pulses and generates the physics tick (slow enable) for the bird datapath.
- Detects collisions with the screen borders and the current pipe, counts passed pipes, and runs the IDLE/PLAYING/DYING/GAME_OVER flow.
- Sits between the keyboard/button input and the bird and pipe datapaths; drives their reset and enables.

Parameters:
N, 10, coordinate width
SCORE_W, 8, score width
TICK_DIV, 6250000, clk cycles per physics tick (8 Hz at 50 MHz)
DEATH_HOLD, 8, ticks spent in DYING before GAME_OVER
BIRD_X, 160, bird centre x
BIRD_SIZE, 15, bird edge length
PIPE_W, 40, pipe width
SCREEN_H, 480, screen height

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key  in  1  raw flap button, asynchronous to clk, active-high
bird_y0  in  N  bird bottom edge (larger y)
bird_y1  in  N  bird top edge
pipe_x  in  N  current pipe left edge
gap_top  in  N  pipe gap upper y
gap_bot  in  N  pipe gap lower y
bird_rst  out  1  holds the bird datapath at its start position
flap  out  1  one-cycle fly-up pulse to the bird
tick  out  1  one-cycle physics/scroll enable
running  out  1  high in PLAYING
game_over  out  1  high in GAME_OVER
score  out  SCORE_W  pipes passed

Behaviour:
- Reset (async, any state): state=IDLE, bird_rst=1, flap=0, tick=0, running=0, game_over=0, score=0, tick counter=0, synchronizer flops=0. All outputs are registered.
- Key path:
  - 2-flop synchronizer followed by an edge register.
  - key_pulse = sync2 & ~key_q.
  - One pulse per press regardless of hold length.
  - flap is high for exactly one cycle, starting 3 rising edges after key is first sampled high.
- Tick:
  - Counter runs 0..TICK_DIV-1 only in PLAYING and DYING.
  - tick=1 for the one cycle after the counter reaches TICK_DIV-1, after which the counter wraps to 0.
  - Counter clears on entry to PLAYING, so the first tick comes TICK_DIV cycles after entry.
  - tick is never asserted in IDLE or GAME_OVER.
- IDLE:
  - bird_rst=1.
  - key_pulse: go to PLAYING, set score=0, set bird_rst=0.
  - The start press does not also produce a flap.
- PLAYING:
  - running=1; flap follows key_pulse.
  - hit = bird_y0 >= SCREEN_H-1, OR bird_y1 == 0, OR (x-overlap AND (bird_y1 < gap_top OR bird_y0 > gap_bot)).
  - x-overlap means pipe span [pipe_x, pipe_x+PIPE_W) intersects [BIRD_X-BIRD_SIZE/2, BIRD_X+BIRD_SIZE/2].
  - pipe_x+PIPE_W is computed at N+1 bits (no wrap).
  - On hit: go to DYING next edge, with flap=0.
- Score:
  - A pass event is registered `passed` (right edge < BIRD_X-BIRD_SIZE/2) going 0→1.
  - A pipe_x respawn at the right moves `passed` 1→0, which does not count.
  - score increments by 1 on a pass event and saturates at 2^SCORE_W-1.
  - Hit and pass in the same cycle: hit wins and score is unchanged.
- DYING:
  - flap is suppressed, key ignored, bird_rst=0 (bird keeps falling).
  - Counts DEATH_HOLD ticks, then goes to GAME_OVER.
- GAME_OVER:
  - game_over=1, score held.
  - key_pulse: go to IDLE and set bird_rst=1.
  - score is kept until the next IDLE→PLAYING transition.
- No state ever produces more than one flap per key press. A key press arriving mid-transition is consumed by at most one state.

Decomposition:
- flappy_pkg holds:
  - `typedef enum logic [1:0] {IDLE, PLAYING, DYING, GAME_OVER} game_state_t`
  - SCREEN_H, BIRD_X, BIRD_SIZE, PIPE_W as shared localparams, also used by bird and pipe.
- One sub-module, key_sync_edge: synchronizer plus rising-edge pulse, with async reset.

Test Plan (TICK_DIV=4, DEATH_HOLD=2):
1. Key held 6 cycles in IDLE → exactly one transition to PLAYING; bird_rst falls; flap stays 0; tick first fires 4 cycles after entry, then every 4th cycle.
2. In PLAYING, key held 10 cycles then a second press → exactly two flap pulses, each 1 cycle wide, each 3 edges after the key rises.
3. bird_y1=240, bird_y0=255, gap 200..300, pipe_x swept 200→100 → no hit; score goes 0→1 when pipe_x=112 (right edge 152); respawn to pipe_x=640 gives no extra count.
4. Same sweep with bird_y0=310 → DYING the edge after pipe_x reaches 167; after 2 ticks GAME_OVER with game_over=1 and score=0; key pulses in DYING are ignored.
5. bird_y0=479 → DYING; bird_y1=0 → DYING.
6. Score at 255, then a pass event → stays 255.
7. GAME_OVER, press key → IDLE with bird_rst=1 and score held; press again → score=0.
8. Assert reset asynchronously mid-PLAYING (between edges) → all outputs at reset values immediately, state IDLE.
